// File: rtl/channel_accumulator_if.sv
// Handshake and control bundle between the convolver MAC stage, the channel
// accumulator and the output writeback stage.
interface channel_accumulator_if #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16,
    parameter int CNT_W = 10
);
    logic             start;
    logic [CNT_W-1:0] num_ch;
    logic [OUT_W-1:0] bias;
    logic             relu_en;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             busy;
    logic             done;
    logic             sat_flag;
    logic [15:0]      sat_count;

    modport master (
        output start, num_ch, bias, relu_en, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy, done, sat_flag, sat_count
    );

    modport slave (
        input  start, num_ch, bias, relu_en, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy, done, sat_flag, sat_count
    );
endinterface

// File: rtl/channel_accumulator.sv
// Sums per-channel MAC results for one output pixel, adds bias, optional ReLU,
// saturates to OUT_W. Define CHACC_SAT_CNT_EN to build the saturation counter.
module channel_accumulator #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16,
    parameter int CNT_W = 10,
    parameter int ACC_W = IN_W + CNT_W
) (
    input logic clk,
    input logic rst,
    channel_accumulator_if.slave bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCUM  = 2'd1;
    localparam logic [1:0] RESULT = 2'd2;

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    logic [1:0]              state;
    logic signed [ACC_W-1:0] acc;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        num_ch_q;
    logic [OUT_W-1:0]        bias_q;
    logic                    relu_q;
    logic                    out_valid_q;
    logic [OUT_W-1:0]        out_data_q;
    logic                    sat_flag_q;

    logic signed [ACC_W-1:0] in_ext;
    logic signed [ACC_W-1:0] bias_ext;
    logic signed [ACC_W-1:0] total;
    logic signed [ACC_W-1:0] rect;
    logic                    relu_sel;
    logic [OUT_W-1:0]        sat_result;
    logic                    clipped;
    logic                    last_beat;
    logic                    handshake;

    // In IDLE the result path works straight off the start inputs so a
    // zero-channel pixel can present sat(bias) on the following cycle.
    always_comb begin
        in_ext   = {{(ACC_W-IN_W){bus.in_data[IN_W-1]}}, bus.in_data};
        if (state == IDLE) begin
            bias_ext = {{(ACC_W-OUT_W){bus.bias[OUT_W-1]}}, bus.bias};
            relu_sel = bus.relu_en;
            total    = bias_ext;
        end else begin
            bias_ext = {{(ACC_W-OUT_W){bias_q[OUT_W-1]}}, bias_q};
            relu_sel = relu_q;
            total    = acc + in_ext + bias_ext;
        end
        rect = (relu_sel && total[ACC_W-1]) ? '0 : total;
        if (rect > SAT_MAX) begin
            sat_result = SAT_MAX[OUT_W-1:0];
            clipped    = 1'b1;
        end else if (rect < SAT_MIN) begin
            sat_result = SAT_MIN[OUT_W-1:0];
            clipped    = 1'b1;
        end else begin
            sat_result = rect[OUT_W-1:0];
            clipped    = 1'b0;
        end
    end

    assign last_beat = (cnt == num_ch_q - CNT_W'(1));
    assign handshake = (state == RESULT) && out_valid_q && bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            acc         <= '0;
            cnt         <= '0;
            num_ch_q    <= '0;
            bias_q      <= '0;
            relu_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            sat_flag_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        num_ch_q <= bus.num_ch;
                        bias_q   <= bus.bias;
                        relu_q   <= bus.relu_en;
                        acc      <= '0;
                        cnt      <= '0;
                        if (bus.num_ch == '0) begin
                            out_data_q  <= sat_result;
                            sat_flag_q  <= clipped;
                            out_valid_q <= 1'b1;
                            state       <= RESULT;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (bus.in_valid) begin
                        acc <= acc + in_ext;
                        cnt <= cnt + CNT_W'(1);
                        if (last_beat) begin
                            out_data_q  <= sat_result;
                            sat_flag_q  <= clipped;
                            out_valid_q <= 1'b1;
                            state       <= RESULT;
                        end
                    end
                end
                RESULT: begin
                    if (handshake) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CHACC_SAT_CNT_EN
    logic [15:0] sat_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_cnt <= '0;
        end else if (handshake && sat_flag_q && sat_cnt != 16'hFFFF) begin
            sat_cnt <= sat_cnt + 16'd1;
        end
    end

    assign bus.sat_count = sat_cnt;
`else
    assign bus.sat_count = 16'd0;
`endif

    assign bus.in_ready  = (state == ACCUM);
    assign bus.busy      = (state != IDLE);
    assign bus.done      = handshake;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.sat_flag  = sat_flag_q;
endmodule

// File: tb/tb_channel_accumulator.sv
// Self-checking bench for channel_accumulator: directed table, randomized
// pixels against an arithmetic model, backpressure and mid-accumulation reset.
module tb_channel_accumulator;
    localparam int IN_W  = 32;
    localparam int OUT_W = 16;
    localparam int CNT_W = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    channel_accumulator_if #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) bus ();

    channel_accumulator #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int n;
        int b;
        bit r;
        int d[4];
        int eo;
        bit es;
        int hold;
    } vec_t;

    vec_t vecs[8];
    int   beat_q[$];
    int   checks = 0;
    int   passes = 0;
    int   exp_sat_count = 0;

    task automatic check_output(input string name, input longint actual, input longint expected);
        checks++;
        if (actual == expected) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input int idx, input int n, input int b, input bit r,
                           input int d0, input int d1, input int d2, input int d3,
                           input int eo, input bit es, input int hold);
        vecs[idx].n = n;   vecs[idx].b = b;   vecs[idx].r = r;
        vecs[idx].d[0] = d0; vecs[idx].d[1] = d1; vecs[idx].d[2] = d2; vecs[idx].d[3] = d3;
        vecs[idx].eo = eo; vecs[idx].es = es; vecs[idx].hold = hold;
    endtask

    // Reference: exact sum of all beats plus bias, rectify, then clamp.
    function automatic void model(input int n, input int b, input bit r,
                                  output int eo, output bit es);
        longint s = longint'(b);
        for (int i = 0; i < n; i++) s += longint'(beat_q[i]);
        if (r && s < 0) s = 0;
        es = 1'b1;
        if (s > 32767) eo = 32767;
        else if (s < -32768) eo = -32768;
        else begin
            eo = int'(s);
            es = 1'b0;
        end
    endfunction

    task automatic note_sat(input bit es);
`ifdef CHACC_SAT_CNT_EN
        if (es && exp_sat_count < 65535) exp_sat_count++;
`else
        if (es) exp_sat_count = exp_sat_count;
`endif
    endtask

    task automatic apply_stimulus(input int n, input int b, input bit r, input int hold,
                                  input bit gaps, input int eo, input bit es);
        check_output("idle_busy", longint'(bus.busy), 0);
        bus.start   = 1'b1;
        bus.num_ch  = CNT_W'(n);
        bus.bias    = OUT_W'(b);
        bus.relu_en = r;
        step();
        bus.start   = 1'b0;
        bus.num_ch  = CNT_W'($urandom);
        bus.bias    = OUT_W'($urandom);
        bus.relu_en = 1'($urandom);
        if (n == 0) begin
            check_output("zero_ch_valid", longint'(bus.out_valid), 1);
            check_output("zero_ch_in_ready", longint'(bus.in_ready), 0);
        end else begin
            for (int i = 0; i < n; i++) begin
                if (gaps) begin
                    repeat ($urandom_range(0, 2)) begin
                        bus.in_valid = 1'b0;
                        bus.in_data  = $urandom;
                        bus.start    = 1'b1;
                        check_output("gap_in_ready", longint'(bus.in_ready), 1);
                        step();
                    end
                    bus.start = 1'b0;
                end
                bus.in_valid = 1'b1;
                bus.in_data  = beat_q[i];
                check_output("accum_in_ready", longint'(bus.in_ready), 1);
                check_output("accum_no_valid", longint'(bus.out_valid), 0);
                step();
            end
            bus.in_valid = 1'b0;
            check_output("latency_valid", longint'(bus.out_valid), 1);
        end
        for (int h = 0; h < hold; h++) begin
            bus.out_ready = 1'b0;
            bus.in_valid  = 1'b1;
            bus.in_data   = $urandom;
            bus.start     = 1'b1;
            #1;
            check_output("hold_valid", longint'(bus.out_valid), 1);
            check_output("hold_data", longint'($signed(bus.out_data)), longint'(eo));
            check_output("hold_in_ready", longint'(bus.in_ready), 0);
            check_output("hold_done", longint'(bus.done), 0);
            step();
        end
        bus.in_valid  = 1'b0;
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        check_output("out_data", longint'($signed(bus.out_data)), longint'(eo));
        check_output("sat_flag", longint'(bus.sat_flag), longint'(es));
        check_output("done_pulse", longint'(bus.done), 1);
        step();
        bus.out_ready = 1'b0;
        note_sat(es);
        check_output("post_valid", longint'(bus.out_valid), 0);
        check_output("post_busy", longint'(bus.busy), 0);
        check_output("post_done", longint'(bus.done), 0);
        check_output("sat_count", longint'(bus.sat_count), longint'(exp_sat_count));
    endtask

    initial begin
        int eo;
        bit es;
        int n;
        bus.start = 1'b0; bus.num_ch = '0; bus.bias = '0; bus.relu_en = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;

        set_vec(0, 3, 5, 0, 100, -20, 7, 0, 92, 0, 0);
        set_vec(1, 2, 0, 1, -50, 10, 0, 0, 0, 0, 0);
        set_vec(2, 2, 0, 0, -50, 10, 0, 0, -40, 0, 0);
        set_vec(3, 4, 0, 0, 20000, 20000, 20000, 20000, 32767, 1, 0);
        set_vec(4, 0, -3, 0, 0, 0, 0, 0, -3, 0, 0);
        set_vec(5, 3, 5, 0, 100, -20, 7, 0, 92, 0, 5);
        set_vec(6, 2, 0, 0, -40000, -1, 0, 0, -32768, 1, 2);
        set_vec(7, 1, -5, 1, 3, 0, 0, 0, 0, 0, 1);

        rst = 1'b1;
        #1;
        check_output("rst_out_valid", longint'(bus.out_valid), 0);
        check_output("rst_in_ready", longint'(bus.in_ready), 0);
        check_output("rst_out_data", longint'(bus.out_data), 0);
        check_output("rst_sat_count", longint'(bus.sat_count), 0);
        step();
        step();
        rst = 1'b0;
        step();

        for (int v = 0; v < 8; v++) begin
            beat_q.delete();
            for (int i = 0; i < vecs[v].n; i++) beat_q.push_back(vecs[v].d[i]);
            apply_stimulus(vecs[v].n, vecs[v].b, vecs[v].r, vecs[v].hold, 1'b0,
                           vecs[v].eo, vecs[v].es);
        end

        for (int t = 0; t < 25; t++) begin
            beat_q.delete();
            n = $urandom_range(0, 6);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) beat_q.push_back(int'($urandom));
                else beat_q.push_back($urandom_range(0, 30000) - 15000);
            end
            eo = 0;
            es = 1'b0;
            begin
                int b = int'($urandom_range(0, 65535)) - 32768;
                bit r = 1'($urandom);
                model(n, b, r, eo, es);
                apply_stimulus(n, b, r, $urandom_range(0, 3), 1'b1, eo, es);
            end
        end

        // Reset in the middle of a four-channel accumulation.
        bus.start = 1'b1; bus.num_ch = CNT_W'(4); bus.bias = 16'd7; bus.relu_en = 1'b0;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 1000;
            step();
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        exp_sat_count = 0;
        check_output("mid_rst_busy", longint'(bus.busy), 0);
        check_output("mid_rst_in_ready", longint'(bus.in_ready), 0);
        check_output("mid_rst_out_valid", longint'(bus.out_valid), 0);
        check_output("mid_rst_out_data", longint'(bus.out_data), 0);
        check_output("mid_rst_sat_flag", longint'(bus.sat_flag), 0);
        check_output("mid_rst_done", longint'(bus.done), 0);
        check_output("mid_rst_sat_count", longint'(bus.sat_count), 0);
        step();
        rst = 1'b0;
        step();
        beat_q.delete();
        beat_q.push_back(9);
        apply_stimulus(1, 1, 1'b0, 0, 1'b0, 10, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/channel_accumulator.md
Name: channel_accumulator

Overview:
- Downstream of the 3x3 MAC stage in the convolver datapath.
- Sums per-channel MAC results for one output pixel across `num_ch` input channels and adds a per-filter bias.
- Applies optional ReLU, then saturates to the activation width.
- Presents the result on a valid/ready handshake toward the output buffer/writeback stage.

Parameters:
- IN_W, 32, width of signed MAC result input (matches MAC output width)
- OUT_W, 16, width of signed activation output (matches line data width)
- CNT_W, 10, width of channel-count field; max channels = 2^CNT_W-1
- ACC_W, IN_W+CNT_W, internal accumulator width; guarantees no internal overflow

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  one-cycle pulse; begins a new pixel accumulation (honoured only in IDLE)
- num_ch  in  CNT_W  number of channel beats to accumulate; sampled on accepted start
- bias  in  OUT_W  signed bias; sampled on accepted start
- relu_en  in  1  ReLU enable; sampled on accepted start
- in_valid  in  1  MAC result valid
- in_ready  out  1  block accepts in_data this cycle
- in_data  in  IN_W  signed MAC result
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  OUT_W  signed saturated result
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse on the cycle the result handshake completes
- sat_flag  out  1  registered with out_data; 1 if the result was clipped
- sat_count  out  16  saturation event counter (see Optional Feature)

Behaviour:
- Reset (rst high, any state, mid-operation included) forces:
  - state=IDLE, accumulator=0, channel counter=0
  - in_ready=0, out_valid=0, out_data=0, sat_flag=0, done=0, sat_count=0
- State machine: IDLE, ACCUM, RESULT.
- IDLE:
  - in_ready=0.
  - start=1 latches num_ch, bias, relu_en; clears acc and count.
  - Next state is ACCUM if num_ch!=0, else RESULT.
  - For num_ch=0: out_data = sat(bias) (ReLU applied if latched), out_valid=1 the next cycle.
- ACCUM:
  - in_ready=1.
  - Each cycle with in_valid&in_ready: acc += sign-extended in_data; count++.
  - Gaps in in_valid are allowed and hold state.
  - On the beat where count==num_ch-1:
    - compute s = acc + in_data + sign-extended bias (ACC_W signed);
    - r = (relu_en && s<0) ? 0 : s;
    - out_data <= sat(r): clip to [-2^(OUT_W-1), 2^(OUT_W-1)-1];
    - sat_flag <= 1 if clipped;
    - out_valid <= 1; state <= RESULT.
- Latency: out_valid rises exactly 1 cycle after the last input beat is accepted.
- RESULT:
  - in_ready=0.
  - out_data, out_valid and sat_flag hold stable until out_ready=1.
  - On out_valid&out_ready: out_valid<=0, done pulses that cycle, state <= IDLE.
  - A new start is accepted at the earliest on the cycle after done.
- start while busy is ignored; latched parameters are unaffected.
- in_valid outside ACCUM is ignored; nothing is consumed.
- No arithmetic rounding: the MAC stage has already scaled the data. Accumulation is exact in ACC_W.
- out_ready asserted in the same cycle out_valid rises completes the handshake in that cycle.

Optional Feature:
- Macro: CHACC_SAT_CNT_EN.
- Defined:
  - sat_count increments by 1 on each completed output handshake with sat_flag=1.
  - Saturates at 16'hFFFF; no wrap.
  - Cleared only by rst.
- Undefined: the counter logic is not compiled and sat_count is tied to 0.

Test Plan:
- start num_ch=3, bias=5, relu_en=0; inputs 100, -20, 7; out_ready=1 -> out_data=92, sat_flag=0, out_valid 1 cycle after 3rd beat, done pulse.
- num_ch=2, bias=0, relu_en=1; inputs -50, 10 -> out_data=0, sat_flag=0. Repeat with relu_en=0 -> out_data=-40.
- num_ch=4, bias=0; four inputs of 20000 -> out_data=32767, sat_flag=1. With CHACC_SAT_CNT_EN, sat_count=1; without it, sat_count=0.
- num_ch=0, bias=-3, relu_en=0 -> out_data=-3 one cycle after start, no input consumed (in_ready never high).
- Backpressure: out_ready=0 for 5 cycles after result -> out_data/out_valid stable, in_ready=0, extra in_valid beats not consumed, start pulse ignored. out_ready=1 -> done, return to IDLE.
- Assert rst mid-ACCUM after 2 of 4 beats -> all outputs 0, IDLE. A fresh start num_ch=1, input 9, bias=1 -> out_data=10.
